// File: rtl/ahbl_master.sv
// ahbl_master
// Turns single-beat commands into AHB-Lite manager transfers. At most one
// transfer is in flight. Each command finishes with a one-cycle rsp_valid
// pulse that carries the read data and the error and timeout flags.
//
// Parameters
//   MAX_WAIT     number of consecutive HREADY=0 data-phase cycles that abort
//                a transfer with a timeout (must be >= 1)
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; ready only while idle
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_size    command fields, captured on acceptance
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata, rsp_err,
//   rsp_timeout            response fields, held between pulses
//   HADDR..HWDATA          AHB-Lite manager outputs
//   HRDATA, HREADY, HRESP  AHB-Lite manager inputs
module ahbl_master #(
  parameter int MAX_WAIT = 255
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [2:0]  cmd_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  // The counter value seen during the final allowed wait cycle.
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          misaligned;
  logic          timeout_hit;

  assign cmd_ready   = (state == ST_IDLE);
  assign accept      = cmd_valid & cmd_ready;
  assign timeout_hit = (state == ST_DATA) && !HREADY && (wait_cnt == LAST_WAIT);

  // A misaligned command is answered locally and never reaches the bus.
  always_comb begin
    misaligned = 1'b0;
    if (cmd_size > 3'd2)
      misaligned = 1'b1;
    else if (cmd_size == 3'd1 && cmd_addr[0])
      misaligned = 1'b1;
    else if (cmd_size == 3'd2 && cmd_addr[1:0] != 2'b00)
      misaligned = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && !misaligned) state_nxt = ST_ADDR;
      ST_ADDR: if (HREADY) state_nxt = ST_DATA;
      ST_DATA: if (HREADY || timeout_hit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // The bus-facing copy of the command is loaded only for aligned commands.
  // A rejected command therefore leaves HADDR/HWRITE/HSIZE untouched.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else if (accept && !misaligned) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      write_q <= cmd_write;
      size_q  <= cmd_size;
    end
  end

  // Cleared when the address phase completes, so it starts at zero in DATA.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      wait_cnt <= '0;
    else if (state == ST_ADDR && HREADY)
      wait_cnt <= '0;
    else if (state == ST_DATA && !HREADY)
      wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept && misaligned) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b0;
      end else if (state == ST_DATA && HREADY) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= write_q ? 32'd0 : HRDATA;
        rsp_err     <= HRESP;
        rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

  assign HTRANS    = (state == ST_ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = addr_q;
  assign HWRITE    = write_q;
  assign HSIZE     = size_q;
  assign HWDATA    = (state == ST_DATA && write_q) ? wdata_q : 32'd0;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahbl_master.sv
// tb_ahbl_master
// Drives directed and random commands into ahbl_master and acts as the
// AHB-Lite subordinate. A command's expected response is queued when the
// command is issued. A separate monitor compares each rsp_valid pulse, and
// the cycle it arrives in, against the head of that queue.
module tb_ahbl_master;

  localparam int MAX_WAIT = 4;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  size;
    int          addr_waits;
    int          data_waits;
    bit          err;
    bit          timeout;
  } cmd_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
    int          cycle;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   failures = 0;
  int   cyc = 0;

  ahbl_master #(.MAX_WAIT(MAX_WAIT)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Counts rising edges. The cycle that follows edge k is cycle k+1.
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference model: the response follows directly from the command and
  // from the subordinate's planned behaviour.
  function automatic exp_t expectResponse(input cmd_t c, input int accept);
    exp_t e;
    bit   mis;
    mis = (c.size > 3'd2) || (c.size == 3'd1 && c.addr[0]) ||
          (c.size == 3'd2 && c.addr[1:0] != 2'b00);
    if (mis) begin
      e.rdata = 32'd0; e.err = 1'b1; e.timeout = 1'b0; e.cycle = accept + 1;
    end else if (c.timeout) begin
      e.rdata = 32'd0; e.err = 1'b1; e.timeout = 1'b1;
      e.cycle = accept + 2 + c.addr_waits + MAX_WAIT;
    end else begin
      e.rdata = c.write ? 32'd0 : c.rdata;
      e.err = c.err; e.timeout = 1'b0;
      e.cycle = accept + 3 + c.addr_waits + c.data_waits;
    end
    return e;
  endfunction

  function automatic bit isMisaligned(input cmd_t c);
    return (c.size > 3'd2) || (c.size == 3'd1 && c.addr[0]) ||
           (c.size == 3'd2 && c.addr[1:0] != 2'b00);
  endfunction

  // Monitor: each response pulse must match the oldest outstanding expectation.
  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        checkOutput("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.timeout});
        checkOutput("rsp_cycle", cyc + 1, e.cycle);
      end
    end
  end

  // Issues one command at a negedge, then plays the subordinate for its bus
  // phases. Returns at the negedge of the cycle that carries the response.
  task automatic applyStimulus(input cmd_t c);
    int accept;
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge HCLK);
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_ready_wait", 32'd0, 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_write = c.write;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    cmd_size  = c.size;
    accept = cyc + 1;
    expq.push_back(expectResponse(c, accept));
    @(negedge HCLK);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    if (isMisaligned(c)) begin
      checkOutput("mis_htrans", {30'd0, HTRANS}, 32'd0);
      checkOutput("mis_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    for (int i = 0; i <= c.addr_waits; i++) begin
      checkOutput("addr_htrans", {30'd0, HTRANS}, 32'd2);
      checkOutput("addr_haddr", HADDR, c.addr);
      checkOutput("addr_hwrite", {31'd0, HWRITE}, {31'd0, c.write});
      checkOutput("addr_hsize", {29'd0, HSIZE}, {29'd0, c.size});
      HREADY = (i == c.addr_waits);
      @(negedge HCLK);
    end
    if (c.timeout) begin
      for (int i = 0; i < MAX_WAIT; i++) begin
        checkOutput("data_htrans", {30'd0, HTRANS}, 32'd0);
        HREADY = 1'b0;
        HRESP  = 1'b0;
        @(negedge HCLK);
      end
      checkOutput("to_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    end else begin
      for (int i = 0; i <= c.data_waits; i++) begin
        checkOutput("data_htrans", {30'd0, HTRANS}, 32'd0);
        checkOutput("data_hwdata", HWDATA, c.write ? c.wdata : 32'd0);
        checkOutput("data_haddr", HADDR, c.addr);
        HREADY = (i == c.data_waits);
        HRESP  = c.err && (i >= c.data_waits - 1);
        HRDATA = (i == c.data_waits) ? c.rdata : $urandom;
        @(negedge HCLK);
      end
    end
    HREADY = 1'b1;
    HRESP  = 1'b0;
  endtask

  function automatic cmd_t makeCmd(input logic write, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input logic [2:0] size, input int aw, input int dw,
                                   input bit err, input bit timeout);
    cmd_t c;
    c.write = write; c.addr = addr; c.wdata = wdata; c.rdata = rdata;
    c.size = size; c.addr_waits = aw; c.data_waits = dw;
    c.err = err; c.timeout = timeout;
    return c;
  endfunction

  function automatic cmd_t randomCmd();
    cmd_t c;
    c.write = $urandom_range(0, 1) == 1;
    c.addr  = $urandom;
    c.wdata = $urandom;
    c.rdata = $urandom;
    c.size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                          : 3'($urandom_range(0, 2));
    if ($urandom_range(0, 3) != 0) begin
      if (c.size == 3'd1) c.addr[0] = 1'b0;
      if (c.size == 3'd2) c.addr[1:0] = 2'b00;
    end
    c.addr_waits = $urandom_range(0, 2);
    c.data_waits = $urandom_range(0, MAX_WAIT - 1);
    c.timeout = $urandom_range(0, 7) == 0;
    c.err = !c.timeout && ($urandom_range(0, 4) == 0);
    if (c.err && c.data_waits == 0) c.data_waits = 1;
    return c;
  endfunction

  // Pulls reset during the data phase of a write and expects the bus to
  // return to idle at once with no response for the aborted command.
  task automatic runResetAbort();
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0100;
    cmd_wdata = 32'hA5A5_5A5A; cmd_size = 3'd2;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    checkOutput("rst_addr_htrans", {30'd0, HTRANS}, 32'd2);
    HREADY = 1'b1;
    @(negedge HCLK);
    HREADY = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    checkOutput("rst_htrans", {30'd0, HTRANS}, 32'd0);
    checkOutput("rst_haddr", HADDR, 32'd0);
    checkOutput("rst_hwdata", HWDATA, 32'd0);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    HREADY = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) begin
      @(negedge HCLK);
      checkOutput("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_size = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) @(negedge HCLK);
    checkOutput("reset_htrans", {30'd0, HTRANS}, 32'd0);
    checkOutput("reset_haddr", HADDR, 32'd0);
    checkOutput("reset_hwrite", {31'd0, HWRITE}, 32'd0);
    checkOutput("reset_hsize", {29'd0, HSIZE}, 32'd0);
    checkOutput("reset_hwdata", HWDATA, 32'd0);
    checkOutput("reset_rsp", {rsp_valid, rsp_err, rsp_timeout}, 32'd0);
    checkOutput("reset_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_hprot", {28'd0, HPROT}, 32'd3);
    checkOutput("reset_hburst", {29'd0, HBURST}, 32'd0);
    checkOutput("reset_hmastlock", {31'd0, HMASTLOCK}, 32'd0);
    checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    HRESETn = 1'b1;
    @(negedge HCLK);

    applyStimulus(makeCmd(1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 3'd2, 0, 0, 1'b0, 1'b0));
    applyStimulus(makeCmd(1'b0, 32'h80, 32'h0, 32'h12345678, 3'd2, 0, 3, 1'b0, 1'b0));
    applyStimulus(makeCmd(1'b0, 32'h84, 32'h0, 32'hCAFEF00D, 3'd2, 0, 1, 1'b1, 1'b0));
    applyStimulus(makeCmd(1'b1, 32'h41, 32'h11111111, 32'h0, 3'd2, 0, 0, 1'b0, 1'b0));
    applyStimulus(makeCmd(1'b1, 32'h43, 32'h22222222, 32'h0, 3'd1, 0, 0, 1'b0, 1'b0));
    applyStimulus(makeCmd(1'b0, 32'h40, 32'h0, 32'h0, 3'd3, 0, 0, 1'b0, 1'b0));
    applyStimulus(makeCmd(1'b0, 32'h90, 32'h0, 32'h0, 3'd2, 1, 0, 1'b0, 1'b1));
    applyStimulus(makeCmd(1'b0, 32'h91, 32'h0, 32'h5A5A5A5A, 3'd0, 0, MAX_WAIT - 1,
                          1'b0, 1'b0));
    @(negedge HCLK);
    checkOutput("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    runResetAbort();
    applyStimulus(makeCmd(1'b1, 32'h200, 32'h0BADF00D, 32'h0, 3'd2, 0, 0, 1'b0, 1'b0));

    for (int k = 0; k < 60; k++)
      applyStimulus(randomCmd());

    repeat (MAX_WAIT + 6) @(negedge HCLK);
    checkOutput("pending_rsp", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/ahbl_master.md
AHBL_MASTER -- requirements
Module: ahbl_master

Interface
REQ-001 Parameter MAX_WAIT, default 255, SHALL set the number of consecutive HREADY=0 data-phase cycles after which a transfer is aborted with a timeout.
REQ-002 HCLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 HRESETn  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-004 cmd_valid  in  1  SHALL indicate a command request.
REQ-005 cmd_ready  out  1  SHALL indicate the block accepts a command.
REQ-006 cmd_write  in  1  SHALL select write (1) or read (0).
REQ-007 cmd_addr  in  32  SHALL be the byte address.
REQ-008 cmd_wdata  in  32  SHALL be the write data.
REQ-009 cmd_size  in  3  SHALL be the AHB transfer size code.
REQ-010 rsp_valid  out  1  SHALL be a one-cycle completion pulse.
REQ-011 rsp_rdata  out  32  SHALL carry read data.
REQ-012 rsp_err  out  1  SHALL flag error, misalignment or timeout.
REQ-013 rsp_timeout  out  1  SHALL flag a timeout abort.
REQ-014 HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3, HBURST out 3, HPROT out 4, HMASTLOCK out 1, HWDATA out 32 SHALL be the AHB-Lite manager outputs.
REQ-015 HRDATA in 32, HREADY in 1, HRESP in 1 SHALL be the AHB-Lite manager inputs.

Function
REQ-016 The block SHALL have an FSM with states IDLE, ADDR, DATA, and one outstanding transfer at most.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid & cmd_ready, and all cmd_* fields are registered then.
REQ-018 On acceptance, a command is misaligned if cmd_size>2, if size=1 with addr[0]=1, or if size=2 with addr[1:0]!=0; in that case the FSM SHALL stay in IDLE, no bus transfer occurs, and the next cycle SHALL pulse rsp_valid=1 with rsp_err=1, rsp_timeout=0 and rsp_rdata=0.
REQ-019 Aligned acceptance SHALL move the FSM IDLE->ADDR.
REQ-020 In ADDR, HTRANS=NONSEQ (2'b10) and HADDR, HWRITE, HSIZE SHALL equal the registered command; the FSM SHALL stay in ADDR while HREADY=0 and move to DATA on HREADY=1.
REQ-021 In IDLE and DATA, HTRANS SHALL be IDLE (2'b00); HADDR, HWRITE and HSIZE SHALL hold their last values.
REQ-022 In DATA, HWDATA SHALL equal the registered wdata for writes and 0 for reads; the wait counter SHALL clear on entry and increment on each HREADY=0 cycle.
REQ-023 In DATA with HREADY=1, the FSM SHALL return to IDLE, and the next cycle SHALL pulse rsp_valid=1 with rsp_err=HRESP, rsp_rdata=HRDATA for reads or 0 for writes, and rsp_timeout=0.
REQ-024 HRESP=1 with HREADY=0 (first error cycle) SHALL NOT end the transfer; completion waits for HREADY=1.
REQ-025 In DATA, if the wait counter reaches MAX_WAIT while HREADY=0, the FSM SHALL go to IDLE and the next cycle SHALL pulse rsp_valid=1 with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-026 HBURST SHALL be constant 3'b000, HPROT constant 4'b0011, and HMASTLOCK constant 0.
REQ-027 Zero-wait latency SHALL be: accept at edge N, ADDR cycle N+1, DATA cycle N+2, rsp_valid at cycle N+3 (the IDLE cycle, cmd_ready=1); a new command may be accepted in the same cycle rsp_valid is high.
REQ-028 rsp_* SHALL be registered and SHALL hold their values outside rsp_valid pulses.

Reset
REQ-029 While HRESETn=0, the FSM SHALL be in IDLE, and HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the wait counter SHALL be 0; HPROT=4'b0011 and cmd_ready=1.
REQ-030 Reset asserted mid-transfer SHALL abort immediately to IDLE with HTRANS=00, and no response SHALL be generated for the aborted command.

Verification
REQ-031 Write, zero waits: addr 0x40, wdata 0xDEADBEEF, size 2 -> HTRANS=10 with HADDR=0x40 one cycle, HWDATA=0xDEADBEEF next cycle, then rsp_valid with rsp_err=0.
REQ-032 Read with 3 wait states, HRDATA=0x12345678 -> rsp_valid 3 cycles later than the zero-wait case, with rsp_rdata=0x12345678.
REQ-033 Two-cycle error response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) -> single rsp_valid with rsp_err=1, rsp_timeout=0.
REQ-034 Misaligned command addr 0x41, size 2 -> HTRANS stays 00, rsp_valid with rsp_err=1 on the cycle after acceptance.
REQ-035 MAX_WAIT=4 with HREADY held 0 in DATA -> rsp_valid with rsp_err=1, rsp_timeout=1, and cmd_ready=1 afterwards.
REQ-036 HRESETn pulsed low during DATA -> HTRANS=00 immediately, no rsp_valid, and the next command runs normally.
